// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and helpers for the branch resolve queue.
package branch_resolve_queue_pkg;

  // One in-flight prediction as issued by the fetch-stage predictor.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  preds;   // {global, local}
  } brq_entry_t;

  // Branch plus delay slot: not-taken fall-through is PC + 8.
  localparam int FALLTHRU_OFFSET_DEF = 8;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Enqueue / resolve / retire signal bundle between the pipeline and the queue.
interface branch_resolve_queue_if;
  // Fetch-side enqueue
  logic        Enq_valid;
  logic [31:0] Enq_PC;
  logic        Enq_taken;
  logic [31:0] Enq_target;
  logic [1:0]  Enq_preds;
  logic        Enq_ready;
  // MEM-side resolution
  logic        Res_valid;
  logic [31:0] Res_PC;
  logic        Res_taken;
  logic [31:0] Res_target;
  // Registered results
  logic        Flush_OUT;
  logic [31:0] Redirect_addr;
  logic        Train_valid;
  logic [1:0]  Train_preds;
  logic        Orphan_OUT;

  // Pipeline side: drives enqueue and resolve, consumes results.
  modport master (
    output Enq_valid, Enq_PC, Enq_taken, Enq_target, Enq_preds,
    output Res_valid, Res_PC, Res_taken, Res_target,
    input  Enq_ready, Flush_OUT, Redirect_addr, Train_valid, Train_preds, Orphan_OUT
  );

  // Queue side.
  modport slave (
    input  Enq_valid, Enq_PC, Enq_taken, Enq_target, Enq_preds,
    input  Res_valid, Res_PC, Res_taken, Res_target,
    output Enq_ready, Flush_OUT, Redirect_addr, Train_valid, Train_preds, Orphan_OUT
  );
endinterface

// File: rtl/branch_resolve_queue_sat_counter.sv
// Saturating up-counter with synchronous clear, used for branch statistics.
module brq_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next value: hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  // Count register; clear is the synchronous reset.
  always_ff @(posedge CLK) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions; checks each against the
// MEM-stage outcome, raises a redirect on mispredict and reports training data.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int FALLTHRU_OFFSET = FALLTHRU_OFFSET_DEF,
  parameter int CNT_W           = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         Flush_IN,
  branch_resolve_queue_if.slave        bus,
  output logic [clog2(DEPTH+1)-1:0]    Count,
  output logic [CNT_W-1:0]             Branch_cnt,
  output logic [CNT_W-1:0]             Mispredict_cnt
);

  localparam int IDX_W = clog2(DEPTH);
  localparam int CW    = clog2(DEPTH+1);

  brq_entry_t       mem_q [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             train_valid_q, train_valid_d;
  logic [1:0]       train_preds_q, train_preds_d;
  logic             orphan_q, orphan_d;

  brq_entry_t head_e;
  logic       enq_ready, match, mispred, clear_all, do_enq, do_deq;

  assign head_e    = mem_q[head_q];
  assign enq_ready = (count_q != CW'(DEPTH));
  assign match     = bus.Res_valid && (count_q != '0) && (head_e.pc == bus.Res_PC);
  assign mispred   = match && ((head_e.taken != bus.Res_taken) ||
                               (bus.Res_taken && (head_e.target != bus.Res_target)));
  // Everything behind a mispredicted head is wrong-path, so it is squashed too.
  assign clear_all = Flush_IN || mispred;
  assign do_enq    = bus.Enq_valid && enq_ready && !clear_all;
  assign do_deq    = match && !clear_all;

  // Next-state for pointers, occupancy and the registered result pulses.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    flush_d       = mispred;
    redirect_d    = redirect_q;
    train_valid_d = match;
    train_preds_d = train_preds_q;
    orphan_d      = bus.Res_valid && !match;
    if (clear_all) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_deq) head_d = head_q + IDX_W'(1);
      if (do_enq) tail_d = tail_q + IDX_W'(1);
      count_d = count_q + CW'(do_enq) - CW'(do_deq);
    end
    if (match) train_preds_d = head_e.preds;
    if (mispred)
      redirect_d = bus.Res_taken ? bus.Res_target : bus.Res_PC + 32'(FALLTHRU_OFFSET);
  end

  // Control and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      train_valid_q <= 1'b0;
      train_preds_q <= '0;
      orphan_q      <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      train_valid_q <= train_valid_d;
      train_preds_q <= train_preds_d;
      orphan_q      <= orphan_d;
    end
  end

  // Entry storage write at tail.
  // NOTE: storage is deliberately not reset; Count gates every read, so stale
  // contents are never observed and the array maps onto plain RAM/regfile.
  always_ff @(posedge CLK) begin
    if (do_enq) mem_q[tail_q] <= '{pc: bus.Enq_PC, taken: bus.Enq_taken,
                                   target: bus.Enq_target, preds: bus.Enq_preds};
  end

  brq_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .CLK   (CLK),
    .clear (RESET),
    .inc   (match),
    .cnt   (Branch_cnt)
  );

  brq_sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .CLK   (CLK),
    .clear (RESET),
    .inc   (mispred),
    .cnt   (Mispredict_cnt)
  );

  assign Count             = count_q;
  assign bus.Enq_ready     = enq_ready;
  assign bus.Flush_OUT     = flush_q;
  assign bus.Redirect_addr = redirect_q;
  assign bus.Train_valid   = train_valid_q;
  assign bus.Train_preds   = train_preds_q;
  assign bus.Orphan_OUT    = orphan_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=8).
module tb_branch_resolve_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Flush_IN;
  logic [3:0]  Count;
  logic [31:0] Branch_cnt;
  logic [31:0] Mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_queue_if bus();

  branch_resolve_queue #(.DEPTH(8), .FALLTHRU_OFFSET(8), .CNT_W(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .Flush_IN       (Flush_IN),
    .bus            (bus),
    .Count          (Count),
    .Branch_cnt     (Branch_cnt),
    .Mispredict_cnt (Mispredict_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic set_idle();
    Flush_IN       = 1'b0;
    bus.Enq_valid  = 1'b0;
    bus.Enq_PC     = '0;
    bus.Enq_taken  = 1'b0;
    bus.Enq_target = '0;
    bus.Enq_preds  = '0;
    bus.Res_valid  = 1'b0;
    bus.Res_PC     = '0;
    bus.Res_taken  = 1'b0;
    bus.Res_target = '0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    set_idle();
  endtask

  task automatic put_enq(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [1:0] pr);
    bus.Enq_valid  = 1'b1;
    bus.Enq_PC     = pc;
    bus.Enq_taken  = tk;
    bus.Enq_target = tgt;
    bus.Enq_preds  = pr;
  endtask

  task automatic put_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.Res_valid  = 1'b1;
    bus.Res_PC     = pc;
    bus.Res_taken  = tk;
    bus.Res_target = tgt;
  endtask

  task automatic test_reset();
    set_idle();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    step();
    n_checks++; if (Count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", Count); end
    n_checks++; if (bus.Enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready got %b want 1", bus.Enq_ready); end
    n_checks++; if ({bus.Flush_OUT, bus.Train_valid, bus.Orphan_OUT} !== 3'b000) begin n_fail++;
      $display("FAIL reset_pulses got %b want 000", {bus.Flush_OUT, bus.Train_valid, bus.Orphan_OUT}); end
    n_checks++; if (Branch_cnt !== 32'd0 || Mispredict_cnt !== 32'd0) begin n_fail++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", Branch_cnt, Mispredict_cnt); end
    n_checks++; if (bus.Redirect_addr !== 32'd0 || bus.Train_preds !== 2'b00) begin n_fail++;
      $display("FAIL reset_regs got %h/%b want 0/00", bus.Redirect_addr, bus.Train_preds); end
  endtask

  task automatic test_correct_predict();
    put_enq(32'h100, 1'b1, 32'h200, 2'b10);
    step();
    n_checks++; if (Count !== 4'd1) begin n_fail++; $display("FAIL corr_count_enq got %0d want 1", Count); end
    put_res(32'h100, 1'b1, 32'h200);
    step();
    n_checks++; if (bus.Train_valid !== 1'b1 || bus.Train_preds !== 2'b10) begin n_fail++;
      $display("FAIL corr_train got %b/%b want 1/10", bus.Train_valid, bus.Train_preds); end
    n_checks++; if (bus.Flush_OUT !== 1'b0) begin n_fail++; $display("FAIL corr_flush got %b want 0", bus.Flush_OUT); end
    n_checks++; if (Count !== 4'd0 || Branch_cnt !== 32'd1) begin n_fail++;
      $display("FAIL corr_state got count %0d bcnt %0d want 0/1", Count, Branch_cnt); end
    step();
    n_checks++; if (bus.Train_valid !== 1'b0) begin n_fail++; $display("FAIL corr_train_pulse got %b want 0", bus.Train_valid); end
  endtask

  task automatic test_mispredict();
    put_enq(32'h100, 1'b0, 32'h0, 2'b01);   step();
    put_enq(32'h108, 1'b1, 32'h120, 2'b11); step();
    put_enq(32'h110, 1'b0, 32'h0, 2'b00);   step();
    n_checks++; if (Count !== 4'd3) begin n_fail++; $display("FAIL misp_count_fill got %0d want 3", Count); end
    put_res(32'h100, 1'b1, 32'h400);
    step();
    n_checks++; if (bus.Flush_OUT !== 1'b1 || bus.Redirect_addr !== 32'h400) begin n_fail++;
      $display("FAIL misp_redirect got %b/%h want 1/00000400", bus.Flush_OUT, bus.Redirect_addr); end
    n_checks++; if (Count !== 4'd0) begin n_fail++; $display("FAIL misp_clear got %0d want 0", Count); end
    n_checks++; if (Mispredict_cnt !== 32'd1 || Branch_cnt !== 32'd2) begin n_fail++;
      $display("FAIL misp_counters got %0d/%0d want 1/2", Mispredict_cnt, Branch_cnt); end
    n_checks++; if (bus.Train_valid !== 1'b1 || bus.Train_preds !== 2'b01) begin n_fail++;
      $display("FAIL misp_train got %b/%b want 1/01", bus.Train_valid, bus.Train_preds); end
    step();
    n_checks++; if (bus.Flush_OUT !== 1'b0) begin n_fail++; $display("FAIL misp_pulse got %b want 0", bus.Flush_OUT); end
  endtask

  task automatic test_fallthru_and_target();
    // Predicted taken, actually not taken: redirect to PC + 8.
    put_enq(32'h300, 1'b1, 32'h380, 2'b00); step();
    put_res(32'h300, 1'b0, 32'h380);        step();
    n_checks++; if (bus.Flush_OUT !== 1'b1 || bus.Redirect_addr !== 32'h308) begin n_fail++;
      $display("FAIL fallthru got %b/%h want 1/00000308", bus.Flush_OUT, bus.Redirect_addr); end
    // Both taken, wrong target.
    put_enq(32'h340, 1'b1, 32'h380, 2'b00); step();
    put_res(32'h340, 1'b1, 32'h390);        step();
    n_checks++; if (bus.Flush_OUT !== 1'b1 || bus.Redirect_addr !== 32'h390) begin n_fail++;
      $display("FAIL target_miss got %b/%h want 1/00000390", bus.Flush_OUT, bus.Redirect_addr); end
    // Both not taken: target field is irrelevant.
    put_enq(32'h360, 1'b0, 32'h999, 2'b00); step();
    put_res(32'h360, 1'b0, 32'h123);        step();
    n_checks++; if (bus.Flush_OUT !== 1'b0 || bus.Train_valid !== 1'b1) begin n_fail++;
      $display("FAIL nt_target_ignored got flush %b train %b want 0/1", bus.Flush_OUT, bus.Train_valid); end
    n_checks++; if (Mispredict_cnt !== 32'd3 || Branch_cnt !== 32'd5) begin n_fail++;
      $display("FAIL ft_counters got %0d/%0d want 3/5", Mispredict_cnt, Branch_cnt); end
  endtask

  task automatic test_full_and_back_to_back();
    for (int i = 0; i < 8; i++) begin
      put_enq(32'h1000 + 32'(8 * i), 1'b1, 32'h2000 + 32'(i), 2'(i));
      step();
    end
    n_checks++; if (Count !== 4'd8 || bus.Enq_ready !== 1'b0) begin n_fail++;
      $display("FAIL full got count %0d ready %b want 8/0", Count, bus.Enq_ready); end
    put_enq(32'h1100, 1'b1, 32'h5000, 2'b11);
    step();
    n_checks++; if (Count !== 4'd8) begin n_fail++; $display("FAIL full_drop got %0d want 8", Count); end
    put_res(32'h1000, 1'b1, 32'h2000);
    step();
    n_checks++; if (Count !== 4'd7 || bus.Train_preds !== 2'b00) begin n_fail++;
      $display("FAIL deq_one got count %0d preds %b want 7/00", Count, bus.Train_preds); end
    // Simultaneous enqueue and correct dequeue at Count=7 (tail wraps to 0).
    put_enq(32'h1200, 1'b1, 32'h3000, 2'b11);
    put_res(32'h1008, 1'b1, 32'h2001);
    step();
    n_checks++; if (Count !== 4'd7 || bus.Train_preds !== 2'b01 || bus.Flush_OUT !== 1'b0) begin n_fail++;
      $display("FAIL b2b got count %0d preds %b flush %b want 7/01/0", Count, bus.Train_preds, bus.Flush_OUT); end
    // Drain in order; the dropped 0x1100 must not appear.
    for (int i = 2; i < 8; i++) begin
      put_res(32'h1000 + 32'(8 * i), 1'b1, 32'h2000 + 32'(i));
      step();
      n_checks++; if (bus.Train_valid !== 1'b1 || bus.Orphan_OUT !== 1'b0 || bus.Train_preds !== 2'(i)) begin n_fail++;
        $display("FAIL drain_%0d got train %b orphan %b preds %b", i, bus.Train_valid, bus.Orphan_OUT, bus.Train_preds); end
    end
    put_res(32'h1200, 1'b1, 32'h3000);
    step();
    n_checks++; if (bus.Train_valid !== 1'b1 || bus.Train_preds !== 2'b11 || Count !== 4'd0) begin n_fail++;
      $display("FAIL wrap_entry got train %b preds %b count %0d want 1/11/0", bus.Train_valid, bus.Train_preds, Count); end
    n_checks++; if (Branch_cnt !== 32'd14 || Mispredict_cnt !== 32'd3) begin n_fail++;
      $display("FAIL full_counters got %0d/%0d want 14/3", Branch_cnt, Mispredict_cnt); end
  endtask

  task automatic test_orphan();
    put_res(32'h500, 1'b1, 32'h600);
    step();
    n_checks++; if (bus.Orphan_OUT !== 1'b1 || bus.Flush_OUT !== 1'b0 || bus.Train_valid !== 1'b0) begin n_fail++;
      $display("FAIL orphan_empty got o%b f%b t%b want 1/0/0", bus.Orphan_OUT, bus.Flush_OUT, bus.Train_valid); end
    n_checks++; if (Count !== 4'd0 || Branch_cnt !== 32'd14 || Mispredict_cnt !== 32'd3) begin n_fail++;
      $display("FAIL orphan_state got %0d/%0d/%0d want 0/14/3", Count, Branch_cnt, Mispredict_cnt); end
    put_enq(32'h700, 1'b1, 32'h710, 2'b10); step();
    put_res(32'h704, 1'b1, 32'h710);        step();
    n_checks++; if (bus.Orphan_OUT !== 1'b1 || Count !== 4'd1) begin n_fail++;
      $display("FAIL orphan_nohead got orphan %b count %0d want 1/1", bus.Orphan_OUT, Count); end
    step();
    n_checks++; if (bus.Orphan_OUT !== 1'b0) begin n_fail++; $display("FAIL orphan_pulse got %b want 0", bus.Orphan_OUT); end
  endtask

  task automatic test_flush_in();
    // Queue holds 0x700; squash with a simultaneous enqueue.
    Flush_IN = 1'b1;
    put_enq(32'h800, 1'b1, 32'h810, 2'b00);
    step();
    n_checks++; if (Count !== 4'd0 || bus.Flush_OUT !== 1'b0 || bus.Enq_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_in got count %0d flush %b ready %b want 0/0/1", Count, bus.Flush_OUT, bus.Enq_ready); end
    // Squash in the same cycle as a mispredicting resolve: resolve still counts.
    put_enq(32'h900, 1'b1, 32'h910, 2'b01); step();
    Flush_IN = 1'b1;
    put_res(32'h900, 1'b0, 32'h910);
    step();
    n_checks++; if (bus.Flush_OUT !== 1'b1 || bus.Redirect_addr !== 32'h908 || Count !== 4'd0) begin n_fail++;
      $display("FAIL flush_in_res got %b/%h/%0d want 1/00000908/0", bus.Flush_OUT, bus.Redirect_addr, Count); end
    n_checks++; if (Branch_cnt !== 32'd15 || Mispredict_cnt !== 32'd4 || bus.Train_preds !== 2'b01) begin n_fail++;
      $display("FAIL flush_in_cnt got %0d/%0d/%b want 15/4/01", Branch_cnt, Mispredict_cnt, bus.Train_preds); end
  endtask

  task automatic test_mispredict_with_enq();
    put_enq(32'hA00, 1'b1, 32'hA10, 2'b00); step();
    put_enq(32'hB00, 1'b1, 32'hB10, 2'b00);
    put_res(32'hA00, 1'b0, 32'hA10);
    step();
    n_checks++; if (Count !== 4'd0 || bus.Flush_OUT !== 1'b1 || bus.Redirect_addr !== 32'hA08) begin n_fail++;
      $display("FAIL misp_enq got %0d/%b/%h want 0/1/00000a08", Count, bus.Flush_OUT, bus.Redirect_addr); end
    put_res(32'hB00, 1'b1, 32'hB10);
    step();
    n_checks++; if (bus.Orphan_OUT !== 1'b1 || Branch_cnt !== 32'd16 || Mispredict_cnt !== 32'd5) begin n_fail++;
      $display("FAIL misp_enq_drop got %b/%0d/%0d want 1/16/5", bus.Orphan_OUT, Branch_cnt, Mispredict_cnt); end
  endtask

  initial begin
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_fallthru_and_target();
    test_full_and_back_to_back();
    test_orphan();
    test_flush_in();
    test_mispredict_with_enq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- FIFO that tracks every in-flight control-transfer prediction, from fetch (where the hybrid predictor issues Taken/Taken_addr/Branch_predictions_OUT) to resolution in MEM.
- At resolution it compares the actual outcome against the stored prediction and raises a one-cycle flush with a redirect PC on mismatch.
- It returns the stored global/local prediction pair so the predictor can train its meta-predictor.
- It keeps saturating statistics counters.

Parameters:
- DEPTH, 8, number of queue entries; power of two, at least 2.
- FALLTHRU_OFFSET, 8, byte offset from branch PC to the not-taken fall-through (branch plus delay slot).
- CNT_W, 32, width of the statistics counters.

Ports:
- CLK  input  1  clock.
- RESET  input  1  synchronous, active-high reset.
- Flush_IN  input  1  external squash (exception); empties the queue.
- Enq_valid  input  1  fetch stage has a predicted branch/jump this cycle.
- Enq_PC  input  32  PC of that instruction.
- Enq_taken  input  1  predicted direction.
- Enq_target  input  32  predicted target.
- Enq_preds  input  2  {global, local} prediction bits.
- Enq_ready  output  1  high when count < DEPTH; combinational.
- Res_valid  input  1  MEM stage resolves a branch/jump this cycle.
- Res_PC  input  32  PC of the resolving instruction.
- Res_taken  input  1  actual direction.
- Res_target  input  32  actual taken target.
- Flush_OUT  output  1  registered one-cycle mispredict pulse.
- Redirect_addr  output  32  correct fetch PC, valid with Flush_OUT.
- Train_valid  output  1  registered pulse: an entry retired.
- Train_preds  output  2  stored {global, local} bits of the retired entry.
- Orphan_OUT  output  1  registered pulse: resolve with no matching head.
- Count  output  $clog2(DEPTH+1)  current occupancy.
- Branch_cnt  output  CNT_W  retired entries.
- Mispredict_cnt  output  CNT_W  mispredicted entries.

Behaviour:
- Reset (RESET=1 at posedge):
  - head, tail and Count go to 0.
  - Flush_OUT, Train_valid and Orphan_OUT go to 0.
  - Redirect_addr and Train_preds go to 0.
  - Both counters go to 0.
  - Storage contents are don't-care.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count changes by +1, -1 or 0 per cycle.
- Enqueue: occurs when Enq_valid & Enq_ready and no squash this cycle. The entry is written at tail {PC, taken, target, preds}, then tail increments. Enq_valid while full is dropped silently; Count is unchanged.
- Match: Res_valid & Count≠0 & head.PC==Res_PC.
- On match, dequeue head, pulse Train_valid next cycle with Train_preds=head.preds, and increment Branch_cnt.
- Mispredict is (head.taken≠Res_taken) | (Res_taken & head.target≠Res_target).
  - Redirect_addr = Res_taken ? Res_target : Res_PC+FALLTHRU_OFFSET, in mod-2^32 arithmetic.
  - Flush_OUT pulses for one cycle.
  - Mispredict_cnt increments.
  - The whole queue is cleared at the same edge; all entries are younger and wrong-path.
- No match while Res_valid:
  - Orphan_OUT pulses; queue, counters and Train_valid are untouched.
  - No flush is generated.
- Outputs have 1-cycle latency: Res_valid at edge N produces Flush_OUT/Train_valid/Orphan_OUT high during cycle N+1, low thereafter unless re-triggered.
- Simultaneous enqueue and correct-prediction dequeue:
  - Both take effect and Count is unchanged.
  - Allowed even when full only if Enq_ready was high; Enq_ready does not look ahead at the dequeue.
- Simultaneous enqueue and mispredict: the mispredict clear wins and the enqueue is dropped.
- Flush_IN:
  - Clears the queue; takes priority over enqueue.
  - A resolve in the same cycle is still evaluated for training, flush and counters before clearing.
  - Flush_IN itself never asserts Flush_OUT.
- Counters saturate at all-ones.
- Priority order: RESET > Flush_IN/mispredict clear > dequeue/enqueue.

Decomposition:
- Shared package holds:
  - entry struct {pc[31:0], taken, target[31:0], preds[1:0]};
  - the FALLTHRU_OFFSET default;
  - the index-width function clog2.
- One natural sub-module, brq_sat_counter (parameterised width, inc, clear), instantiated twice for the statistics counters.
- FIFO storage and control stay inline.

Test Plan:
- Reset then idle → Count=0, Enq_ready=1, all pulses 0, counters 0.
- Enqueue PC 0x100 (taken, target 0x200, preds 2'b10); resolve 0x100 taken 0x200 → Train_valid=1, Train_preds=2'b10 next cycle, Flush_OUT=0, Count=0, Branch_cnt=1.
- Enqueue 0x100 predicted not-taken plus 0x108, 0x110; resolve 0x100 taken 0x400 → Flush_OUT=1, Redirect_addr=0x400, Count=0, Mispredict_cnt=1.
- Enqueue 0x300 predicted taken; resolve not-taken → Redirect_addr=0x308.
- Fill to DEPTH=8 → Enq_ready=0 and a 9th enqueue is dropped. Then enqueue and correct-dequeue in one cycle with Count=7 → Count stays 7.
- Resolve 0x500 with empty queue → Orphan_OUT=1 only. Flush_IN with simultaneous enqueue → Count=0 and no Flush_OUT.
